sram_ctrl: RTL and testbench

//  Sequences single-word reads/writes to the external async SRAM for the CPU datapath.

---
 rtl/sram_ctrl_if.sv | 41 ++++
 rtl/sram_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Bundles the CPU request/response signals, the external SRAM strobes/address
// and the tristate buffer connections of one SRAM controller.
//
// Handshake: the master raises req together with we/addr/wdata; the request is
// accepted on the first rising Clk edge where the controller is idle (busy=0 and
// no DONE cycle in progress). There is no ready signal and no queueing.
// Completion is the single-cycle done pulse. rdata stays valid from the done pulse
// of a read until the next read completes.
interface sram_ctrl_if #(
    parameter int N      = 16,
    parameter int ADDR_W = 20
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      wdata;
    logic [N-1:0]      rdata;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] ADDR;
    logic              CE_N;
    logic              UB_N;
    logic              LB_N;
    logic              OE_N;
    logic              WE_N;
    logic              tri_OE;
    logic [N-1:0]      tri_In;
    logic [N-1:0]      tri_Out;

    // Requester plus SRAM/tristate side, i.e. everything around the controller
    modport master (
        output req, we, addr, wdata, tri_Out,
        input  rdata, done, busy, ADDR, CE_N, UB_N, LB_N, OE_N, WE_N, tri_OE, tri_In
    );

    // The controller itself
    modport slave (
        input  req, we, addr, wdata, tri_Out,
        output rdata, done, busy, ADDR, CE_N, UB_N, LB_N, OE_N, WE_N, tri_OE, tri_In
    );
endinterface

// File: rtl/sram_ctrl.sv
// Single-word read/write sequencer for an external asynchronous SRAM.
// Every strobe is registered and decoded from the next state, so the pins
// never glitch and a transition happens exactly on a Clk edge.
module sram_ctrl #(
    parameter int N            = 16,
    parameter int ADDR_W       = 20,
    parameter int RD_WAIT_CYC  = 2,
    parameter int WR_PULSE_CYC = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    sram_ctrl_if.slave bus,
    output logic [2:0] dbg_state
);
    localparam int MAX_CYC = (RD_WAIT_CYC > WR_PULSE_CYC) ? RD_WAIT_CYC : WR_PULSE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counters hold "cycles remaining after this one", so a stretch of C cycles loads C-1
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACCESS = 3'd1,
        RD_LATCH  = 3'd2,
        WR_SETUP  = 3'd3,
        WR_PULSE  = 3'd4,
        WR_HOLD   = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [N-1:0]      wdata_q;
    logic [N-1:0]      rdata_q;
    logic              accept;

    // Decoded next values of the registered outputs
    logic ce_n_d, oe_n_d, we_n_d, tri_oe_d, done_d, busy_d;
    // Registered outputs
    logic ce_n_q, oe_n_q, we_n_q, tri_oe_q, done_q, busy_q;

    assign accept    = (state == IDLE) && bus.req;
    assign dbg_state = state;

    // State register and wait counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; the counter reloads on every state entry and only counts down to zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bus.we) begin
                        state_nxt = WR_SETUP;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        state_nxt = RD_ACCESS;
                        cnt_nxt   = RD_LOAD;
                    end
                end
            end
            RD_ACCESS: begin
                if (cnt == CNT_ZERO) begin
                    state_nxt = RD_LATCH;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RD_LATCH: begin
                state_nxt = DONE;
                cnt_nxt   = CNT_ZERO;
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = WR_LOAD;
            end
            WR_PULSE: begin
                if (cnt == CNT_ZERO) begin
                    state_nxt = WR_HOLD;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            WR_HOLD: begin
                state_nxt = DONE;
                cnt_nxt   = CNT_ZERO;
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state; OE_N is only ever low while tri_OE is low
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        tri_oe_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_nxt != IDLE);
        case (state_nxt)
            RD_ACCESS: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d   = 1'b0;
                tri_oe_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d   = 1'b0;
                we_n_d   = 1'b0;
                tri_oe_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    // Output register; reset forces strobes inactive immediately, even mid-pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            tri_oe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            tri_oe_q <= tri_oe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Request latch; address and write data stay on the pins until the next accept
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Read capture; the buffer's registered bus sample is valid during RD_LATCH
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (state == RD_LATCH) begin
            rdata_q <= bus.tri_Out;
        end
    end

    assign bus.CE_N   = ce_n_q;
    assign bus.UB_N   = ce_n_q;
    assign bus.LB_N   = ce_n_q;
    assign bus.OE_N   = oe_n_q;
    assign bus.WE_N   = we_n_q;
    assign bus.tri_OE = tri_oe_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.ADDR   = addr_q;
    assign bus.tri_In = wdata_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a default build (2/2 wait cycles) and a 1/1 build,
// each with a behavioural async SRAM plus registered tristate buffer around it.
module tb_sram_ctrl;
    localparam int N  = 16;
    localparam int AW = 20;
    localparam int RD = 2;
    localparam int WR = 2;

    logic Clk = 1'b0;
    logic Reset;
    logic [2:0] dbg_a, dbg_b;
    int total = 0;
    int bad   = 0;

    logic [N-1:0] mem_a [logic [AW-1:0]];
    logic [N-1:0] mem_b [logic [AW-1:0]];

    // Clock and reset
    always #5 Clk = ~Clk;

    sram_ctrl_if #(.N(N), .ADDR_W(AW)) bus_a ();
    sram_ctrl_if #(.N(N), .ADDR_W(AW)) bus_b ();

    sram_ctrl #(.N(N), .ADDR_W(AW), .RD_WAIT_CYC(RD), .WR_PULSE_CYC(WR)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a.slave), .dbg_state(dbg_a)
    );
    sram_ctrl #(.N(N), .ADDR_W(AW), .RD_WAIT_CYC(1), .WR_PULSE_CYC(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b.slave), .dbg_state(dbg_b)
    );

    // SRAM + tristate model A: buffer registers the bus each Clk; SRAM writes while WE_N low
    always @(posedge Clk) begin
        if (!bus_a.CE_N && !bus_a.OE_N && bus_a.WE_N)
            bus_a.tri_Out <= mem_a.exists(bus_a.ADDR) ? mem_a[bus_a.ADDR] : 16'hDEAD;
        else if (bus_a.tri_OE)
            bus_a.tri_Out <= bus_a.tri_In;
        if (!bus_a.CE_N && !bus_a.WE_N && bus_a.tri_OE)
            mem_a[bus_a.ADDR] = bus_a.tri_In;
    end

    // SRAM + tristate model B
    always @(posedge Clk) begin
        if (!bus_b.CE_N && !bus_b.OE_N && bus_b.WE_N)
            bus_b.tri_Out <= mem_b.exists(bus_b.ADDR) ? mem_b[bus_b.ADDR] : 16'hDEAD;
        else if (bus_b.tri_OE)
            bus_b.tri_Out <= bus_b.tri_In;
        if (!bus_b.CE_N && !bus_b.WE_N && bus_b.tri_OE)
            mem_b[bus_b.ADDR] = bus_b.tri_In;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus invariants, checked every cycle on both builds
    always @(negedge Clk) begin
        check("inv_oe_a", {63'd0, bus_a.tri_OE && !bus_a.OE_N}, 64'd0);
        check("inv_we_a", {63'd0, !bus_a.WE_N && !(!bus_a.CE_N && bus_a.tri_OE)}, 64'd0);
        check("inv_oe_b", {63'd0, bus_b.tri_OE && !bus_b.OE_N}, 64'd0);
    end

    // {CE_N,UB_N,LB_N,OE_N,WE_N,tri_OE,done,busy}
    function automatic logic [7:0] pins_a();
        return {bus_a.CE_N, bus_a.UB_N, bus_a.LB_N, bus_a.OE_N, bus_a.WE_N,
                bus_a.tri_OE, bus_a.done, bus_a.busy};
    endfunction

    // Full transaction on build A with per-cycle strobe expectations
    task automatic txn_a(input logic w, input logic [AW-1:0] a, input logic [N-1:0] d,
                         input logic [N-1:0] exp_rd, input string tag);
        int last;
        logic ce, oe, wen, toe, dn;
        last = w ? WR + 3 : RD + 2;
        @(negedge Clk);
        bus_a.req = 1'b1; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
        for (int k = 1; k <= last; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                bus_a.req = 1'b0; bus_a.addr = ~a; bus_a.wdata = ~d;
            end
            if (w) begin
                ce  = !(k <= WR + 2);
                oe  = 1'b1;
                wen = !(k >= 2 && k <= WR + 1);
                toe = (k <= WR + 2);
            end else begin
                ce  = !(k <= RD);
                oe  = !(k <= RD);
                wen = 1'b1;
                toe = 1'b0;
            end
            dn = (k == last);
            check($sformatf("%s_pins_c%0d", tag, k), {56'd0, pins_a()},
                  {56'd0, ce, ce, ce, oe, wen, toe, dn, 1'b1});
            check($sformatf("%s_addr_c%0d", tag, k), {44'd0, bus_a.ADDR}, {44'd0, a});
            if (w) check($sformatf("%s_triin_c%0d", tag, k), {48'd0, bus_a.tri_In}, {48'd0, d});
        end
        check({tag, "_rdata"}, {48'd0, bus_a.rdata}, {48'd0, exp_rd});
        @(negedge Clk);
        check({tag, "_idle"}, {56'd0, pins_a()}, {56'd0, 8'b1111_1000});
    endtask

    // Transaction on build B returning the cycle in which done was seen (0 = never)
    task automatic txn_b(input logic w, input logic [AW-1:0] a, input logic [N-1:0] d,
                         output int done_k);
        done_k = 0;
        @(negedge Clk);
        bus_b.req = 1'b1; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            if (k == 1) bus_b.req = 1'b0;
            if (bus_b.done && done_k == 0) done_k = k;
        end
    endtask

    // Directed sequence
    initial begin
        int dcnt;
        int kb;
        int acc;
        logic [AW-1:0] base;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.tri_Out = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.tri_Out = '0;
        Reset = 1'b1;
        mem_a[20'h00ABC] = 16'hBEEF;
        repeat (2) @(negedge Clk);
        check("rst_pins", {56'd0, pins_a()}, {56'd0, 8'b1111_1000});
        check("rst_rdata", {48'd0, bus_a.rdata}, 64'd0);
        check("rst_addr", {44'd0, bus_a.ADDR}, 64'd0);
        check("rst_triin", {48'd0, bus_a.tri_In}, 64'd0);
        check("rst_state", {61'd0, dbg_a}, 64'd0);
        Reset = 1'b0;

        // Reads, writes, readbacks, top-of-range address
        txn_a(1'b0, 20'h00ABC, 16'h0000, 16'hBEEF, "rd_beef");
        txn_a(1'b1, 20'h12345, 16'h1234, 16'hBEEF, "wr_1234");
        check("mem_12345", {48'd0, mem_a.exists(20'h12345) ? mem_a[20'h12345] : 16'hXXXX},
              {48'd0, 16'h1234});
        txn_a(1'b0, 20'h12345, 16'h0000, 16'h1234, "rd_back");
        txn_a(1'b1, 20'hFFFFF, 16'hA5A5, 16'h1234, "wr_top");
        txn_a(1'b0, 20'hFFFFF, 16'h0000, 16'hA5A5, "rd_top");

        // Reset while idle clears rdata and keeps strobes inactive
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("idle_rst_pins", {56'd0, pins_a()}, {56'd0, 8'b1111_1000});
        check("idle_rst_rdata", {48'd0, bus_a.rdata}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // req held high: reads accepted at cycles 0,5,10; done at 4,9,14
        base = 20'h00AB0;
        dcnt = 0;
        @(negedge Clk);
        bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = base;
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clk);
            acc = 5 * ((k - 1) / 5);
            check($sformatf("hold_db_c%0d", k), {62'd0, bus_a.done, bus_a.busy},
                  {62'd0, (k % 5) == 4, (k % 5) != 0});
            check($sformatf("hold_addr_c%0d", k), {44'd0, bus_a.ADDR},
                  {44'd0, base + AW'(acc)});
            if (bus_a.done) dcnt++;
            bus_a.addr = base + AW'(k);
            if (k == 15) bus_a.req = 1'b0;
        end
        check("hold_done_cnt", 64'(dcnt), 64'd3);
        @(negedge Clk);
        check("hold_end_state", {61'd0, dbg_a}, 64'd0);

        // Reset during the first WR_PULSE cycle
        @(negedge Clk);
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 20'h55555; bus_a.wdata = 16'h7777;
        @(negedge Clk);
        bus_a.req = 1'b0;
        @(negedge Clk);
        check("pulse_we_low", {63'd0, bus_a.WE_N}, 64'd0);
        #2 Reset = 1'b1;
        #1;
        check("pulse_rst_pins", {56'd0, pins_a()}, {56'd0, 8'b1111_1000});
        @(negedge Clk);
        Reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (bus_a.done) dcnt++;
            check($sformatf("pulse_rst_idle%0d", k), {61'd0, dbg_a}, 64'd0);
        end
        check("pulse_rst_nodone", 64'(dcnt), 64'd0);
        check("pulse_rst_nowrite", {63'd0, mem_a.exists(20'h55555)}, 64'd0);

        // Build with single wait cycles
        txn_b(1'b1, 20'h0F0F0, 16'hC3C3, kb);
        check("b_wr_done_cycle", 64'(kb), 64'd4);
        txn_b(1'b0, 20'h0F0F0, 16'h0000, kb);
        check("b_rd_done_cycle", 64'(kb), 64'd3);
        check("b_rd_data", {48'd0, bus_b.rdata}, {48'd0, 16'hC3C3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
